// File: rtl/irq_select_controller.sv
// irq_select_controller: edge-latched, masked, fixed-priority interrupt selector driving decoder S
module irq_select_controller #(
  parameter int SEL_W = 4,
  parameter int NUM_IRQ = 2 ** SEL_W,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic               CLK,
  input  logic               RST_N,
  input  logic [NUM_IRQ-1:0] irq_in,
  input  logic               mask_wr,
  input  logic [NUM_IRQ-1:0] mask_data,
  input  logic               eoi,
  input  logic               int_ack,
  output logic               int_req,
  output logic [SEL_W-1:0]   int_sel,
  output logic               busy,
  output logic [NUM_IRQ-1:0] pending,
  output logic [NUM_IRQ-1:0] mask_out,
  output logic               timeout
);
  typedef enum logic [1:0] {IDLE, REQ, SVC} state_t;
  state_t state, state_n;
  logic [NUM_IRQ-1:0] hist, elig, clr;
  logic [SEL_W-1:0] win, sel_n;
  logic req_n, busy_n, to_hit, to_n;
  assign elig = pending & ~mask_out;
`ifdef IRQ_TIMEOUT_EN
  logic [7:0] cnt;
  assign to_hit = (cnt == 8'(TIMEOUT_CYC - 1));
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      cnt <= '0;
      timeout <= 1'b0;
    end else begin
      cnt <= (state == REQ) ? cnt + 8'd1 : 8'd0;
      timeout <= to_n;
    end
  end
`else
  assign to_hit = 1'b0;
  assign timeout = 1'b0;
`endif
  always_comb begin
    win = '0;
    for (int i = NUM_IRQ - 1; i >= 0; i--)
      if (elig[i]) win = SEL_W'(i);
  end
  always_comb begin
    state_n = state;
    req_n = int_req;
    sel_n = int_sel;
    busy_n = busy;
    to_n = 1'b0;
    clr = '0;
    case (state)
      IDLE: if (|elig) begin
        state_n = REQ;
        req_n = 1'b1;
        sel_n = win;
      end
      REQ: if (int_ack) begin
        state_n = SVC;
        req_n = 1'b0;
        busy_n = 1'b1;
        clr = NUM_IRQ'(1) << int_sel;
      end else if (to_hit) begin
        state_n = IDLE;
        req_n = 1'b0;
        to_n = 1'b1;
      end
      SVC: if (eoi) begin
        state_n = IDLE;
        busy_n = 1'b0;
      end
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state <= IDLE;
      int_req <= 1'b0;
      int_sel <= '0;
      busy <= 1'b0;
      pending <= '0;
      mask_out <= '1;
      hist <= '0;
    end else begin
      state <= state_n;
      int_req <= req_n;
      int_sel <= sel_n;
      busy <= busy_n;
      hist <= irq_in;
      pending <= (pending & ~clr) | (irq_in & ~hist);
      if (mask_wr) mask_out <= mask_data;
    end
  end
endmodule

// File: tb/tb_irq_select_controller.sv
// tb_irq_select_controller: directed self-checking bench for irq_select_controller
module tb_irq_select_controller;
  logic CLK = 1'b0, RST_N = 1'b0;
  logic [15:0] irq_in = '0, mask_data = '0;
  logic mask_wr = 1'b0, eoi = 1'b0, int_ack = 1'b0;
  logic int_req, busy, timeout;
  logic [3:0] int_sel;
  logic [15:0] pending, mask_out;
  int checks = 0, failures = 0;
  always #5 CLK = ~CLK;
  irq_select_controller #(.TIMEOUT_CYC(4)) dut (
    .CLK(CLK), .RST_N(RST_N), .irq_in(irq_in), .mask_wr(mask_wr), .mask_data(mask_data),
    .eoi(eoi), .int_ack(int_ack), .int_req(int_req), .int_sel(int_sel), .busy(busy),
    .pending(pending), .mask_out(mask_out), .timeout(timeout)
  );
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic chk_out(input string tag, input logic req, input logic [3:0] sel,
                         input logic bsy, input logic [15:0] pend);
    chk({tag, "_req"}, 32'(int_req), 32'(req));
    chk({tag, "_sel"}, 32'(int_sel), 32'(sel));
    chk({tag, "_busy"}, 32'(busy), 32'(bsy));
    chk({tag, "_pend"}, 32'(pending), 32'(pend));
  endtask
  initial begin
    tick(); tick();
    chk_out("reset", 0, 0, 0, 16'h0000);
    chk("reset_mask", 32'(mask_out), 32'hFFFF);
    chk("reset_to", 32'(timeout), 0);
    RST_N = 1;
    mask_wr = 1; mask_data = 16'h0000; tick(); mask_wr = 0;
    chk("unmask", 32'(mask_out), 32'h0000);
    irq_in = 16'h0020; tick();
    irq_in = 16'h0000; tick();
    chk_out("req5", 1, 5, 0, 16'h0020);
    RST_N = 0; tick(); RST_N = 1;
    chk_out("rst_mid", 0, 0, 0, 16'h0000);
    chk("rst_mid_mask", 32'(mask_out), 32'hFFFF);
    mask_wr = 1; mask_data = 16'h0000; tick(); mask_wr = 0;
    irq_in = 16'h0200; tick();
    chk_out("b_pend", 0, 0, 0, 16'h0200);
    tick();
    chk_out("b_req", 1, 9, 0, 16'h0200);
    int_ack = 1; tick(); int_ack = 0;
    chk_out("b_ack", 0, 9, 1, 16'h0000);
    tick();
    chk_out("b_level", 0, 9, 1, 16'h0000);
    eoi = 1; tick(); eoi = 0; irq_in = 16'h0000;
    chk_out("b_eoi", 0, 9, 0, 16'h0000);
    eoi = 1; tick(); eoi = 0;
    chk_out("stray_eoi", 0, 9, 0, 16'h0000);
    mask_wr = 1; mask_data = 16'h0008; tick(); mask_wr = 0;
    irq_in = 16'h1088; tick();
    chk_out("p_pend", 0, 9, 0, 16'h1088);
    irq_in = 16'h0000; tick();
    chk_out("p_req7", 1, 7, 0, 16'h1088);
    int_ack = 1; tick();
    chk_out("p_ack7", 0, 7, 1, 16'h1008);
    tick(); int_ack = 0;
    chk_out("stray_ack", 0, 7, 1, 16'h1008);
    eoi = 1; tick(); eoi = 0;
    chk_out("p_eoi7", 0, 7, 0, 16'h1008);
    tick();
    chk_out("p_req12", 1, 12, 0, 16'h1008);
    int_ack = 1; tick(); int_ack = 0;
    eoi = 1; tick(); eoi = 0;
    chk_out("p_eoi12", 0, 12, 0, 16'h0008);
    tick();
    chk_out("p_masked3", 0, 12, 0, 16'h0008);
    mask_wr = 1; mask_data = 16'h0000; tick(); mask_wr = 0;
    chk_out("p_unmask", 0, 12, 0, 16'h0008);
    tick();
    chk_out("p_req3", 1, 3, 0, 16'h0008);
    int_ack = 1; tick(); int_ack = 0;
    eoi = 1; tick(); eoi = 0;
    chk_out("p_done", 0, 3, 0, 16'h0000);
    irq_in = 16'h0010; tick();
    irq_in = 16'h0000; tick();
    chk_out("s_req4", 1, 4, 0, 16'h0010);
    irq_in = 16'h0010; int_ack = 1; tick(); int_ack = 0; irq_in = 16'h0000;
    chk_out("s_ack", 0, 4, 1, 16'h0010);
    eoi = 1; tick(); eoi = 0;
    tick();
    chk_out("s_rereq4", 1, 4, 0, 16'h0010);
    int_ack = 1; tick(); int_ack = 0;
    eoi = 1; tick(); eoi = 0;
    chk_out("s_done", 0, 4, 0, 16'h0000);
    irq_in = 16'h0004; tick();
    irq_in = 16'h0000; tick();
    chk_out("t_req2", 1, 2, 0, 16'h0004);
    tick(); tick(); tick();
    chk_out("t_wait3", 1, 2, 0, 16'h0004);
    chk("t_wait3_to", 32'(timeout), 0);
    tick();
`ifdef IRQ_TIMEOUT_EN
    chk_out("t_expire", 0, 2, 0, 16'h0004);
    chk("t_pulse", 32'(timeout), 1);
    tick();
    chk_out("t_rereq", 1, 2, 0, 16'h0004);
    chk("t_pulse_end", 32'(timeout), 0);
    tick(); tick(); tick();
    int_ack = 1; tick(); int_ack = 0;
    chk_out("t_ackwins", 0, 2, 1, 16'h0000);
    chk("t_ackwins_to", 32'(timeout), 0);
`else
    chk_out("t_noexpire", 1, 2, 0, 16'h0004);
    chk("t_tied0", 32'(timeout), 0);
    repeat (20) tick();
    chk_out("t_still", 1, 2, 0, 16'h0004);
    int_ack = 1; tick(); int_ack = 0;
    chk_out("t_ack", 0, 2, 1, 16'h0000);
`endif
    eoi = 1; tick(); eoi = 0;
    chk_out("t_done", 0, 2, 0, 16'h0000);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/irq_select_controller.md
Name: irq_select_controller

Overview:
- Sequences the 16-way memory-map/interrupt decoder.
- Latches rising edges on 16 interrupt lines into a pending register and applies a software mask.
- Selects the highest-priority unmasked pending line and drives its 4-bit index onto the decoder select input (S).
- Runs a request/acknowledge/end-of-interrupt handshake with the CPU, so only one line is in service at a time.

Parameters:
- NUM_IRQ, 16, number of interrupt lines; fixed to 2**SEL_W.
- SEL_W, 4, width of the select index driven to the decoder.
- TIMEOUT_CYC, 255, acknowledge timeout in cycles; used only when IRQ_TIMEOUT_EN is defined; range 1..255.

Ports:
- CLK  in  1  system clock; all state updates on the rising edge.
- RST_N  in  1  synchronous, active-low reset; sampled on the rising edge of CLK.
- irq_in  in  16  raw interrupt lines; rising-edge sensitive.
- mask_wr  in  1  write strobe for the mask register.
- mask_data  in  16  new mask value; 1 = line masked.
- eoi  in  1  end-of-interrupt pulse from the CPU.
- int_ack  in  1  CPU acknowledge of int_req.
- int_req  out  1  interrupt request to the CPU.
- int_sel  out  4  selected line index; connects to decoder S.
- busy  out  1  a line is in service (state SVC).
- pending  out  16  pending register contents.
- mask_out  out  16  mask register contents.
- timeout  out  1  one-cycle pulse on acknowledge timeout; tied 0 when IRQ_TIMEOUT_EN is undefined.

Behaviour:
- Reset (RST_N=0 at a CLK edge) wins over every other event, including mid-handshake. Reset values:
  - state = IDLE, int_req = 0, int_sel = 0, busy = 0, timeout = 0;
  - pending = 16'h0000, mask_out = 16'hFFFF, edge history = 16'h0000.
- Edge detect:
  - Edge history register captures irq_in each cycle.
  - pending[i] sets on the next edge when irq_in[i]=1 and the history bit = 0.
  - A level held high sets pending only once.
- Mask: mask_wr=1 loads mask_data on the next edge. Masking does not clear pending bits.
- Eligible vector = pending & ~mask_out. Priority is fixed: lowest index wins.
- FSM states: IDLE, REQ, SVC.
- IDLE:
  - If the eligible vector is nonzero, load int_sel with the winning index, set int_req=1, go to REQ.
  - Latency: irq edge sampled at edge n -> pending set at n -> int_req high after edge n+1.
- REQ:
  - int_req and int_sel are held stable.
  - A mask write that masks the selected line does not withdraw the request; the request is committed.
  - On int_ack=1: clear pending[int_sel], set int_req=0, set busy=1, go to SVC. int_sel holds.
- SVC:
  - int_sel holds.
  - On eoi=1: set busy=0 and go to IDLE. A new selection is possible one cycle later.
- Simultaneous set and clear of the same pending bit (new edge in the same cycle as int_ack): set wins, and the bit stays pending.
- int_ack outside REQ is ignored. eoi outside SVC is ignored.
- int_ack and eoi are treated as single-cycle pulses. A held int_ack acts only on the REQ->SVC transition.
- All outputs are registered; there is no combinational path from any input to any output.

Optional Feature:
- Macro IRQ_TIMEOUT_EN.
- When defined:
  - An 8-bit counter clears on entry to REQ and increments each REQ cycle.
  - When the count reaches TIMEOUT_CYC with no int_ack: set int_req=0, pulse timeout for one cycle, return to IDLE.
  - pending is untouched, so the line is re-arbitrated on the next cycle.
  - int_ack in the same cycle as the count reaching TIMEOUT_CYC: ack wins, and no timeout pulse is generated.
- When undefined:
  - No counter is built; REQ waits for int_ack indefinitely.
  - timeout is constant 0.

Test Plan:
- Reset mid-REQ:
  - Stimulus: pulse irq_in[5], hold int_ack=0, then assert RST_N=0 for one edge.
  - Required: int_req=0, int_sel=0, pending=0, mask_out=FFFF.
- Basic handshake:
  - Stimulus: unmask all (mask_data=0000); rising edge on irq_in[9].
  - Required:
    - pending=0200, then int_req=1 with int_sel=9 two edges after the sampled edge.
    - int_ack -> pending=0000, busy=1.
    - eoi -> busy=0, state IDLE.
- Priority and masking:
  - Stimulus: mask=0008; edges on lines 3, 7 and 12 in the same cycle.
  - Required:
    - Service order is int_sel=7, then 12.
    - Line 3 stays pending (pending=0008) and is never requested until a mask write of 0000, after which int_sel=3.
- Set beats clear:
  - Stimulus: line 4 in REQ; a new rising edge on irq_in[4] in the same cycle as int_ack.
  - Required: pending[4] remains 1; line 4 is requested again after eoi.
- Stray handshakes:
  - Stimulus: eoi while in IDLE; int_ack while in SVC.
  - Required: no state, pending or output change.
- Timeout (IRQ_TIMEOUT_EN defined, TIMEOUT_CYC=4):
  - Stimulus: edge on line 2, no ack.
  - Required:
    - After 4 REQ cycles: int_req=0, timeout pulse of 1 cycle, pending[2]=1, int_req reasserted for line 2.
    - Repeat with int_ack on the 4th REQ cycle -> no timeout pulse.
